// File: rtl/pause_dim_ctrl_if.sv
// Bundles the pause/dim controller's request, status and RGB stream signals.
// Latency: none (wires only); the controller adds 1 cycle on rgb_out.
// Backpressure: none; the video stream and pause levels are free-running.
//
// Ports carried:
//   pause_btn, pause_req, osd_open, osd_pause_en, rgb_in -> into controller
//   rgb_out, pause_core, user_paused, dim_active         <- from controller
// master = the side that drives the inputs (joystick/core/testbench),
// slave  = the controller itself.
interface pause_dim_ctrl_if #(
    parameter int R_W = 3,
    parameter int G_W = 3,
    parameter int B_W = 2
);
    localparam int RGB_W = R_W + G_W + B_W;

    logic             pause_btn;
    logic             pause_req;
    logic             osd_open;
    logic             osd_pause_en;
    logic [RGB_W-1:0] rgb_in;
    logic [RGB_W-1:0] rgb_out;
    logic             pause_core;
    logic             user_paused;
    logic             dim_active;

    modport master (
        output pause_btn, pause_req, osd_open, osd_pause_en, rgb_in,
        input  rgb_out, pause_core, user_paused, dim_active
    );

    modport slave (
        input  pause_btn, pause_req, osd_open, osd_pause_en, rgb_in,
        output rgb_out, pause_core, user_paused, dim_active
    );
endinterface

// File: rtl/pause_dim_ctrl.sv
// Merges user/external/OSD pause into one core pause and dims RGB after a long user pause.
// Latency: pause_core combinational; rgb_out, dim_active registered (1 clk_sys cycle).
// Backpressure: none; stream is passed every cycle, no stalls.
//
// Ports:
//   clk_sys  - system clock, rising edge
//   reset    - asynchronous, active-high
//   io       - pause_dim_ctrl_if.slave: pause_btn/pause_req/osd_open/osd_pause_en/rgb_in in,
//              rgb_out/pause_core/user_paused/dim_active out
// Build option: define PAUSE_FADE_EN for a stepped fade (one bit per FADE_STEP cycles)
// instead of an immediate jump to DIM_SHIFT.
module pause_dim_ctrl #(
    parameter int                  R_W        = 3,
    parameter int                  G_W        = 3,
    parameter int                  B_W        = 2,
    parameter int                  TIMER_W    = 32,
    parameter logic [TIMER_W-1:0]  DIM_CYCLES = 'hABA9500,
    parameter int                  DIM_SHIFT  = 1,
    parameter int                  FADE_STEP  = 'h100000
) (
    input  logic             clk_sys,
    input  logic             reset,
    pause_dim_ctrl_if.slave  io
);
    localparam int         RGB_W   = R_W + G_W + B_W;
    localparam logic [2:0] DIM_LVL = 3'(DIM_SHIFT);

    if (DIM_SHIFT < 1 || DIM_SHIFT > 7 || FADE_STEP < 1) begin : g_param_check
        $error("pause_dim_ctrl: DIM_SHIFT must be 1..7 and FADE_STEP at least 1");
    end

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_DIMMED = 2'd2
    } state_t;

    state_t             state;
    logic               toggle;
    logic               btn_prev;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         level;
    logic [RGB_W-1:0]   rgb_q;
    logic               dim_q;
    logic               rise;

`ifdef PAUSE_FADE_EN
    localparam logic [TIMER_W-1:0] FADE_LAST = TIMER_W'(FADE_STEP - 1);
    logic [TIMER_W-1:0] step_cnt;
`endif

    // Per-channel attenuation; shifting by >= channel width naturally yields 0.
    logic [R_W-1:0] r_dim;
    logic [G_W-1:0] g_dim;
    logic [B_W-1:0] b_dim;

    always_comb begin
        r_dim = io.rgb_in[RGB_W-1 -: R_W]     >> level;
        g_dim = io.rgb_in[G_W+B_W-1 -: G_W]   >> level;
        b_dim = io.rgb_in[B_W-1:0]            >> level;
    end

    assign rise = io.pause_btn & ~btn_prev;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            toggle   <= 1'b0;
            // Held high so a button pressed through reset is not seen as a rise.
            btn_prev <= 1'b1;
            timer    <= '0;
            level    <= 3'd0;
            rgb_q    <= '0;
            dim_q    <= 1'b0;
`ifdef PAUSE_FADE_EN
            step_cnt <= '0;
`endif
        end else begin
            btn_prev <= io.pause_btn;
            // Output uses the level held before this edge, together with this edge's rgb_in.
            rgb_q    <= {r_dim, g_dim, b_dim};
            dim_q    <= (level != 3'd0);

            // Only the user toggle runs the idle timer; external pauses never dim.
            if (!toggle) begin
                timer <= '0;
            end else if (timer < DIM_CYCLES) begin
                timer <= timer + 1'b1;
            end

            case (state)
                ST_RUN: begin
                    if (rise) begin
                        state  <= ST_PAUSED;
                        toggle <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    // A rise takes priority over reaching the dim threshold.
                    if (rise) begin
                        state  <= ST_RUN;
                        toggle <= 1'b0;
                        timer  <= '0;
                        level  <= 3'd0;
                    end else if (timer == DIM_CYCLES) begin
                        state <= ST_DIMMED;
`ifdef PAUSE_FADE_EN
                        step_cnt <= '0;
`else
                        level <= DIM_LVL;
`endif
                    end
                end
                ST_DIMMED: begin
                    if (rise) begin
                        state  <= ST_RUN;
                        toggle <= 1'b0;
                        timer  <= '0;
                        level  <= 3'd0;
`ifdef PAUSE_FADE_EN
                    end else if (level != DIM_LVL) begin
                        if (step_cnt == FADE_LAST) begin
                            step_cnt <= '0;
                            level    <= level + 3'd1;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    toggle <= 1'b0;
                    timer  <= '0;
                    level  <= 3'd0;
                end
            endcase
        end
    end

    assign io.rgb_out     = rgb_q;
    assign io.pause_core  = toggle | io.pause_req | (io.osd_open & io.osd_pause_en);
    assign io.user_paused = toggle;
    assign io.dim_active  = dim_q;
endmodule
